// File: rtl/chan_mux_pkg.sv
// chan_mux_pkg: shared types and helpers for the channel display mux.
// Used by chan_mux_seq, chan_mux_timer and chan_mux_seq_if.
package chan_mux_pkg;

   typedef enum logic {SHOW, BLNK} state_t;

   function automatic int cw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // First enabled channel after cur, wrapping; cur when none other.
   function automatic logic [3:0] next_ch(
      input logic [3:0]  cur,
      input logic [15:0] mask,
      input int          n
   );
      logic [3:0] r;
      int         idx;
      r = cur;
      for (int i = n - 1; i >= 1; i--) begin
         idx = (int'(cur) + i) % n;
         if (mask[idx[3:0]]) r = idx[3:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/chan_mux_seq_if.sv
// chan_mux_seq_if: source/display bundle for chan_mux_seq.
// With CHMUX_MASK_EN defined the bundle carries ch_en.
interface chan_mux_seq_if #(
   parameter int N_CH  = 4,
   parameter int WIDTH = 3
);
   import chan_mux_pkg::*;
   localparam int CW = cw(N_CH);

   logic [N_CH*WIDTH-1:0] src;
   logic [CW-1:0]         sel;
   logic                  mode;
   logic [WIDTH-1:0]      result;
   logic [CW-1:0]         active_ch;
   logic                  switching;
`ifdef CHMUX_MASK_EN
   logic [N_CH-1:0]       ch_en;

   modport master (
      output src, sel, mode, ch_en,
      input  result, active_ch, switching
   );
   modport slave (
      input  src, sel, mode, ch_en,
      output result, active_ch, switching
   );
`else
   modport master (
      output src, sel, mode,
      input  result, active_ch, switching
   );
   modport slave (
      input  src, sel, mode,
      output result, active_ch, switching
   );
`endif
endinterface

// File: rtl/chan_mux_timer.sv
// chan_mux_timer: dwell and blank counters with load/expire strobes.
module chan_mux_timer
   import chan_mux_pkg::*;
#(
   parameter int DWELL = 8,
   parameter int BLANK = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic dw_clr,
   input  logic dw_run,
   input  logic bl_load,
   input  logic bl_run,
   output logic dw_exp,
   output logic bl_exp
);
   localparam int DW = cw(DWELL);
   localparam int BW = cw(BLANK);
   localparam int BL = (BLANK > 0) ? BLANK - 1 : 0;

   logic [DW-1:0] dw_cnt;
   logic [BW-1:0] bl_cnt;

   assign dw_exp = (dw_cnt == DW'(DWELL - 1));
   assign bl_exp = (bl_cnt == '0);

   always_ff @(posedge clk) begin
      if (rst)
         dw_cnt <= '0;
      else if (dw_clr)
         dw_cnt <= '0;
      else if (dw_run)
         dw_cnt <= dw_exp ? '0 : dw_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         bl_cnt <= '0;
      else if (bl_load)
         bl_cnt <= BW'(BL);
      else if (bl_run && !bl_exp)
         bl_cnt <= bl_cnt - 1'b1;
   end

endmodule

// File: rtl/chan_mux_seq.sv
// chan_mux_seq: registered N-channel display selector with blanking.
// Define CHMUX_MASK_EN to add per-channel enables (bus.ch_en).
module chan_mux_seq
   import chan_mux_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int WIDTH = 3,
   parameter int DWELL = 8,
   parameter int BLANK = 1
) (
   input logic           clk,
   input logic           rst,
   chan_mux_seq_if.slave bus
);
   localparam int CW = cw(N_CH);
   localparam int EW = 1 << CW;

   state_t           state;
   logic [WIDTH-1:0] res_q;
   logic [CW-1:0]    ch_q;
   logic             sw_q;

   logic [WIDTH-1:0] ch_v [N_CH];
   logic [N_CH-1:0]  en;
   logic [EW-1:0]    en_x;
   logic [CW-1:0]    nxt;
   logic [CW-1:0]    tgt;
   logic             any_en;
   logic             cur_ok;
   logic             req_ok;
   logic             go;
   logic             dw_exp;
   logic             bl_exp;
   logic             dw_clr;
   logic             dw_run;
   logic             bl_load;
   logic             bl_run;

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      assign ch_v[k] = bus.src[k*WIDTH +: WIDTH];
   end

`ifdef CHMUX_MASK_EN
   assign en = bus.ch_en;
`else
   assign en = '1;
`endif

   // Out-of-range sel values land on zero bits and are ignored.
   always_comb begin
      en_x = '0;
      en_x[N_CH-1:0] = en;
   end

   assign any_en = |en;
   assign cur_ok = en_x[ch_q];
   assign req_ok = !bus.mode && en_x[bus.sel]
                && (bus.sel != ch_q);
   assign nxt = CW'(next_ch(4'(ch_q), 16'(en), N_CH));

   always_comb begin
      go  = 1'b0;
      tgt = ch_q;
      if (req_ok) begin
         go  = 1'b1;
         tgt = bus.sel;
      end else if (!cur_ok) begin
         go  = 1'b1;
         tgt = nxt;
      end else if (bus.mode && dw_exp && state == SHOW) begin
         go  = (nxt != ch_q);
         tgt = nxt;
      end
   end

   assign dw_clr  = !bus.mode || !any_en
                 || (state == SHOW && go);
   assign dw_run  = (state == SHOW);
   assign bl_load = (state == SHOW) && go;
   assign bl_run  = (state == BLNK);

   chan_mux_timer #(
      .DWELL (DWELL),
      .BLANK (BLANK)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .dw_clr  (dw_clr),
      .dw_run  (dw_run),
      .bl_load (bl_load),
      .bl_run  (bl_run),
      .dw_exp  (dw_exp),
      .bl_exp  (bl_exp)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= SHOW;
         res_q <= '0;
         ch_q  <= '0;
         sw_q  <= 1'b0;
      end else if (!any_en) begin
         state <= SHOW;
         res_q <= '0;
         sw_q  <= 1'b0;
      end else begin
         ch_q <= tgt;
         unique case (state)
            SHOW: begin
               if (go && BLANK > 0) begin
                  state <= BLNK;
                  res_q <= '0;
                  sw_q  <= 1'b1;
               end else begin
                  res_q <= ch_v[tgt];
               end
            end
            BLNK: begin
               if (bl_exp) begin
                  state <= SHOW;
                  sw_q  <= 1'b0;
                  res_q <= ch_v[tgt];
               end
            end
         endcase
      end
   end

   assign bus.result    = res_q;
   assign bus.active_ch = ch_q;
   assign bus.switching = sw_q;

endmodule
